// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
// Optional sticky "seen" output is enabled with SEQ_DET_STICKY_EN.
package seq_det_pkg;

    localparam int MAX_LEN_DEF = 8;
    localparam int CNT_W_DEF   = 8;

    function automatic int unsigned clamp_len(
        input int unsigned len,
        input int unsigned max
    );
        return (len > max) ? max : len;
    endfunction

    // Patterns never exceed 32 bits, so a 32-bit mask covers every MAX_LEN.
    function automatic logic [31:0] pat_mask(input int unsigned len);
        return (len >= 32) ? 32'hFFFF_FFFF : ((32'd1 << len) - 32'd1);
    endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating match counter with clear priority; optional sticky seen flag.
// The seen flop exists only when SEQ_DET_STICKY_EN is defined.
module seq_det_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
`ifdef SEQ_DET_STICKY_EN
    output logic             seen,
`endif
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

`ifdef SEQ_DET_STICKY_EN
    logic seen_q, seen_d;

    always_comb begin
        seen_d = seen_q;
        if (clr) begin
            seen_d = 1'b0;
        end else if (inc) begin
            seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q <= 1'b0;
        end else begin
            seen_q <= seen_d;
        end
    end

    assign seen = seen_q;
`endif

endmodule

// File: rtl/param_seq_detector.sv
// Runtime-loadable serial pattern detector with overlap control and counter.
// Define SEQ_DET_STICKY_EN to add the sticky "seen" output.
module param_seq_detector
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN       = MAX_LEN_DEF,
    parameter int                 LEN_W         = $clog2(MAX_LEN + 1),
    parameter logic [MAX_LEN-1:0] RESET_PATTERN = MAX_LEN'(8'b0000_0101),
    parameter int                 RESET_LEN     = 3,
    parameter int                 CNT_W         = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in,
    input  logic               in_valid,
    input  logic               overlap,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cnt_clr,
`ifdef SEQ_DET_STICKY_EN
    output logic               seen,
`endif
    output logic               out,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               out_q, out_d;

    logic [MAX_LEN-1:0] hist_sh;
    logic [LEN_W-1:0]   fill_inc;
    logic [31:0]        diff32;
    logic [31:0]        mask32;
    logic               hit;

    assign hist_sh  = {hist_q[MAX_LEN-2:0], in};
    assign fill_inc = (fill_q == MAX_L) ? MAX_L : fill_q + LEN_W'(1);
    assign diff32   = 32'(hist_sh ^ pat_q);
    assign mask32   = pat_mask(32'(len_q));

    // A bit arriving with cfg_load is discarded, so it can never match.
    assign hit = in_valid && !cfg_load && (len_q != '0) &&
                 (fill_inc >= len_q) && ((diff32 & mask32) == 32'd0);

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        len_d  = len_q;
        out_d  = 1'b0;
        if (cfg_load) begin
            pat_d  = cfg_pattern;
            len_d  = LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));
            hist_d = '0;
            fill_d = '0;
        end else if (in_valid) begin
            hist_d = hist_sh;
            fill_d = (hit && !overlap) ? '0 : fill_inc;
            out_d  = hit;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= RESET_PATTERN;
            len_q  <= LEN_W'(RESET_LEN);
            out_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            out_q  <= out_d;
        end
    end

    assign out = out_q;

    seq_det_sat_cnt #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst_n(reset),
        .inc  (hit),
        .clr  (cnt_clr),
`ifdef SEQ_DET_STICKY_EN
        .seen (seen),
`endif
        .count(match_cnt)
    );

endmodule

// File: tb/tb_param_seq_detector.sv
// Self-checking bench: directed table, hand sequences, random vs queue model.
// Uses CNT_W=2 so counter saturation is reached quickly.
module tb_param_seq_detector;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       b = 1'b0;
    logic       vld = 1'b0;
    logic       ovl = 1'b0;
    logic       ld = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] pat = 8'd0;
    logic [3:0] len = 4'd0;
    logic       out;
    logic [1:0] cnt;
`ifdef SEQ_DET_STICKY_EN
    logic       seen;
`endif

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    param_seq_detector #(
        .MAX_LEN(8),
        .CNT_W  (2)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .in         (b),
        .in_valid   (vld),
        .overlap    (ovl),
        .cfg_load   (ld),
        .cfg_pattern(pat),
        .cfg_len    (len),
        .cnt_clr    (clr),
`ifdef SEQ_DET_STICKY_EN
        .seen       (seen),
`endif
        .out        (out),
        .match_cnt  (cnt)
    );

    typedef struct {
        bit         b;
        bit         vld;
        bit         ovl;
        bit         ld;
        bit         clr;
        logic [7:0] pat;
        logic [3:0] len;
        bit         eo;
        logic [1:0] ec;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(bit ib, bit iv, bit io, bit il, bit ic,
                       logic [7:0] ip, logic [3:0] in_len,
                       bit eo, logic [1:0] ec);
        vec_t v;
        v.b = ib; v.vld = iv; v.ovl = io; v.ld = il; v.clr = ic;
        v.pat = ip; v.len = in_len; v.eo = eo; v.ec = ec;
        tbl.push_back(v);
    endtask

    task automatic add_stream(logic [7:0] p, logic [1:0] ec_end,
                              logic [1:0] ec_mid, bit clr_last);
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) add(p[i], 1, 1, 0, clr_last, 0, 0, 1, ec_end);
            else        add(p[i], 1, 1, 0, 0, 0, 0, 0, ec_mid);
        end
    endtask

    // Reference model: queue of fresh bits, newest at the back.
    bit         mq[$];
    logic [7:0] mpat;
    int         mlen;
    int         mcnt;
    bit         mseen;
    bit         mout;

    task automatic model_reset();
        mq.delete();
        mpat = 8'b0000_0101;
        mlen = 3;
        mcnt = 0;
        mseen = 0;
        mout = 0;
    endtask

    task automatic model_step();
        bit h;
        h = 0;
        if (ld) begin
            mpat = pat;
            mlen = (int'(len) > 8) ? 8 : int'(len);
            mq.delete();
        end else if (vld) begin
            mq.push_back(b);
            if (mq.size() > 8) void'(mq.pop_front());
            h = (mlen != 0) && (mq.size() >= mlen);
            if (h) begin
                for (int k = 0; k < mlen; k++)
                    if (mq[mq.size() - 1 - k] != mpat[k]) h = 0;
            end
            if (h && !ovl) mq.delete();
        end
        mout = h;
        if (clr) begin
            mcnt = 0;
            mseen = 0;
        end else if (h) begin
            if (mcnt < 3) mcnt++;
            mseen = 1;
        end
    endtask

    initial begin
        logic [7:0] p;
        p = 8'b1101_0011;

        // A: default 101 pattern, overlapping
        add(1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 1, 1);
        add(0, 1, 1, 0, 0, 0, 0, 0, 1);
        add(1, 1, 1, 0, 0, 0, 0, 1, 2);
        add(1, 0, 1, 0, 0, 0, 0, 0, 2);
        // B: same stream, non-overlapping
        add(1, 1, 0, 1, 1, 8'd5, 4'd3, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 1, 1);
        add(0, 1, 0, 0, 0, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0, 0, 0, 1);
        // C: gaps in the valid strobe
        add(0, 0, 1, 1, 0, 8'd5, 4'd3, 0, 1);
        add(1, 1, 1, 0, 0, 0, 0, 0, 1);
        add(1, 0, 1, 0, 0, 0, 0, 0, 1);
        add(1, 0, 1, 0, 0, 0, 0, 0, 1);
        add(1, 0, 1, 0, 0, 0, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0, 0, 1);
        add(1, 1, 1, 0, 0, 0, 0, 1, 2);
        // D: bit coincident with cfg_load is dropped
        add(1, 1, 1, 1, 1, 8'd5, 4'd3, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 1, 1);
        // E: full 8-bit pattern
        add(0, 0, 1, 1, 0, p, 4'd8, 0, 1);
        add_stream(p, 2, 1, 0);
        // F: length 9 clamps to 8
        add(0, 0, 1, 1, 0, p, 4'd9, 0, 2);
        add_stream(p, 3, 2, 0);
        // G: saturation, then clear colliding with a match
        add_stream(p, 3, 3, 0);
        add_stream(p, 0, 3, 1);
        // H: zero length disables detection
        add(0, 0, 1, 1, 1, 8'd0, 4'd0, 0, 0);
        for (int i = 0; i < 10; i++)
            add(i[0] & i[2], 1, i[1], 0, 0, 0, 0, 0, 0);

        // reset state
        step();
        chk("reset out", 32'(out), 0);
        chk("reset cnt", 32'(cnt), 0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            b = tbl[i].b; vld = tbl[i].vld; ovl = tbl[i].ovl;
            ld = tbl[i].ld; clr = tbl[i].clr;
            pat = tbl[i].pat; len = tbl[i].len;
            step();
            chk($sformatf("tbl[%0d] out", i), 32'(out), 32'(tbl[i].eo));
            chk($sformatf("tbl[%0d] cnt", i), 32'(cnt), 32'(tbl[i].ec));
        end

        // mid-stream asynchronous reset
        ld = 1; clr = 1; pat = 8'd5; len = 4'd3; vld = 0; ovl = 1;
        step();
        ld = 0; clr = 0; vld = 1;
        b = 1; step();
        b = 0; step();
        b = 1; step();
        chk("pre-reset out", 32'(out), 1);
        rst_n = 1'b0;
        #1;
        chk("async reset out", 32'(out), 0);
        chk("async reset cnt", 32'(cnt), 0);
        vld = 0;
        step();
        rst_n = 1'b1;
        vld = 1; b = 1; step();
        chk("post-reset single bit", 32'(out), 0);
        b = 0; step();
        b = 1; step();
        chk("post-reset default pat out", 32'(out), 1);
        chk("post-reset default pat cnt", 32'(cnt), 1);

        // randomized against the model
        vld = 0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            b = 1'($urandom);
            vld = ($urandom % 10) < 7;
            ovl = 1'($urandom);
            ld = ($urandom % 50) == 0;
            clr = ($urandom % 40) == 0;
            if (ld) begin
                pat = 8'($urandom);
                len = 4'($urandom_range(0, 9));
            end
            model_step();
            step();
            chk($sformatf("rand[%0d] out", i), 32'(out), 32'(mout));
            chk($sformatf("rand[%0d] cnt", i), 32'(cnt), 32'(mcnt));
`ifdef SEQ_DET_STICKY_EN
            chk($sformatf("rand[%0d] seen", i), 32'(seen), 32'(mseen));
`endif
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/param_seq_detector.md
Name: param_seq_detector

Overview:
Parametrised serial bit-pattern detector, successor to the fixed "101" detector.
- Target pattern and its length are runtime-loadable, up to MAX_LEN bits.
- Selectable overlapping or non-overlapping detection.
- Input is qualified by a valid strobe.
- Output is a registered one-cycle match pulse plus a saturating match counter.
- Sits on any serial bitstream front end (UART RX data, line decoders) as the framing/sync-word detector.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..32)
LEN_W, $clog2(MAX_LEN+1), width of length fields (derived, not overridden)
RESET_PATTERN, 8'b0000_0101, active pattern after reset; LSB = most recent bit
RESET_LEN, 3, active pattern length after reset
CNT_W, 8, match counter width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous active-low reset (reset=0 resets)
in  input  1  serial data bit
in_valid  input  1  in is sampled on this cycle
overlap  input  1  1 = overlapping detection, 0 = non-overlapping
cfg_load  input  1  one-cycle strobe; latch cfg_pattern/cfg_len
cfg_pattern  input  MAX_LEN  new pattern; bit 0 = last bit received
cfg_len  input  LEN_W  new pattern length
out  output  1  match pulse
match_cnt  output  CNT_W  saturating count of matches
cnt_clr  input  1  synchronous clear of match_cnt

Behaviour:
- Reset (async assert, sync release assumed upstream):
  - out=0, match_cnt=0, history=0, fill=0.
  - Active pattern=RESET_PATTERN, active length=RESET_LEN.
- State:
  - history: MAX_LEN-bit shift register.
  - fill: 0..MAX_LEN, number of valid bits held.
  - act_pat, act_len: active configuration registers.
- in_valid=1: history_n = {history[MAX_LEN-2:0], in}; fill_n = min(fill+1, MAX_LEN).
- in_valid=0: history and fill hold; out=0 next cycle.
- Match condition (evaluated on history_n): in_valid & act_len!=0 & fill_n>=act_len & history_n[act_len-1:0]==act_pat[act_len-1:0].
- out is registered: it goes high the cycle after the clock edge that samples the completing bit, for exactly one cycle. Latency is 1 clk.
- Overlap mode (overlap=1): history and fill are unaffected by a match; bits are reused.
- Non-overlap mode (overlap=0): on a match, fill is cleared to 0, so the next match needs act_len fresh bits.
- overlap may change at any cycle and takes effect on the next valid bit.
- cfg_load=1:
  - act_pat<=cfg_pattern; act_len<=min(cfg_len, MAX_LEN).
  - history and fill cleared; out<=0.
  - A simultaneous in_valid bit is discarded.
  - match_cnt is unaffected.
- act_len=0: detection disabled; out stays 0. Bits above act_len-1 in act_pat are ignored.
- match_cnt: +1 per match, saturating at 2^CNT_W-1 (no wrap).
  - cnt_clr sets it to 0 next cycle.
  - cnt_clr has priority over a simultaneous match; that match is not counted, but out still pulses.
- Reset mid-stream: all state returns to reset values immediately; partial matches are lost.

Optional Feature:
- Macro SEQ_DET_STICKY_EN.
- When defined: adds output port seen (1 bit). seen is set on the first match after reset or cnt_clr and stays high until cnt_clr or reset.
  - If cnt_clr and a match occur in the same cycle, seen is cleared.
- When undefined: the seen port and its flop do not exist; all other behaviour is identical.

Decomposition:
- Package seq_det_pkg:
  - localparam defaults for MAX_LEN/CNT_W.
  - Function clamp_len(len, max) returning the clamped LEN_W value.
  - Function pat_mask(len) returning a MAX_LEN-bit mask with the low len bits set.
- Sub-module seq_det_sat_cnt (CNT_W parameter; inputs inc and clr, clr priority; output count; saturating). It holds the counter and, when SEQ_DET_STICKY_EN is defined, the seen flop.
- Shift register and compare stay in the top module.

Test Plan:
- Reset defaults, overlap=1: valid bits 1,0,1,0,1 on consecutive cycles -> out pulses one cycle after the 3rd and after the 5th bit; match_cnt=2.
- Same stream with overlap=0 -> out pulses only after the 3rd bit; match_cnt=1.
- cfg_load with cfg_pattern=8'b1101_0011, cfg_len=8, then stream 1,1,0,1,0,0,1,1 (MSB first) -> single out pulse after the 8th bit. Then cfg_len=9 -> clamped to 8; cfg_len=0 -> no pulses for any stream.
- Gaps: 1, (in_valid=0 for 3 cycles), 0, 1 -> out pulses once, after the final valid bit; out=0 throughout the gap cycles.
- CNT_W=2: five matches -> match_cnt=3 (saturated). cnt_clr coincident with a 6th match -> match_cnt=0, out=1.
- Reset driven low after bits 1,0 -> out=0, match_cnt=0. After release, a single 1 -> no pulse (fill=1).
